radix4_divider: RTL and testbench

- Iterative unsigned radix-4 restoring divider. Responder side of the `input_valid`/`output_valid` handshake that the muldiv section of the ALU drives.
- Takes magnitudes only. Sign handling and the final divide-by-zero override stay in the ALU.
- Produces 2 quotient bits per cycle, so a 32-bit divide takes 16 iteration cycles.
- Quotient and remainder are registered and held stable until the next operation is accepted, because the ALU reads them combinationally.

---
 rtl/radix4_divider.sv | 130 +++++++++++++
 tb/tb_radix4_divider.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_divider.sv
// Iterative unsigned radix-4 restoring divider: two quotient bits per cycle,
// results held in registers until the next operation completes.
module radix4_divider #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = WIDTH / 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             input_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             output_valid,
   output logic             busy
);

   localparam int unsigned PW = WIDTH + 2;
   localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dq_q, dq_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [PW-1:0]    d3_q, d3_d;
   // Only the low WIDTH bits of the partial remainder ever feed the next step.
   logic [WIDTH-1:0] pr_q, pr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_d, remainder_d;
   logic             output_valid_d, busy_d;

   logic [PW-1:0]    t, d1_ext, d2_ext, sub;
   logic [1:0]       digit;
   logic [WIDTH-1:0] pr_nxt, dq_nxt;

   // Digit selection and one restoring step
   always_comb begin
      t      = {pr_q, dq_q[WIDTH-1:WIDTH-2]};
      d1_ext = {2'b00, d_q};
      d2_ext = {1'b0, d_q, 1'b0};
      digit  = 2'd0;
      sub    = '0;
      if (t >= d3_q) begin
         digit = 2'd3;
         sub   = d3_q;
      end else if (t >= d2_ext) begin
         digit = 2'd2;
         sub   = d2_ext;
      end else if (t >= d1_ext) begin
         digit = 2'd1;
         sub   = d1_ext;
      end
      pr_nxt = WIDTH'(t - sub);
      dq_nxt = {dq_q[WIDTH-3:0], digit};
   end

   // Next-state and register updates
   always_comb begin
      state_d        = state_q;
      dq_d           = dq_q;
      d_d            = d_q;
      d3_d           = d3_q;
      pr_d           = pr_q;
      cnt_d          = cnt_q;
      quotient_d     = quotient;
      remainder_d    = remainder;
      output_valid_d = 1'b0;
      busy_d         = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (input_valid) begin
               state_d = CALC;
               dq_d    = dividend;
               d_d     = divisor;
               d3_d    = PW'(divisor) + {1'b0, divisor, 1'b0};
               pr_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CALC: begin
            pr_d  = pr_nxt;
            dq_d  = dq_nxt;
            cnt_d = CW'(cnt_q + 1'b1);
            if (cnt_q == CW'(ITER - 1)) begin
               state_d        = DONE;
               quotient_d     = dq_nxt;
               remainder_d    = pr_nxt;
               output_valid_d = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         dq_q         <= '0;
         d_q          <= '0;
         d3_q         <= '0;
         pr_q         <= '0;
         cnt_q        <= '0;
         quotient     <= '0;
         remainder    <= '0;
         output_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         dq_q         <= dq_d;
         d_q          <= d_d;
         d3_q         <= d3_d;
         pr_q         <= pr_d;
         cnt_q        <= cnt_d;
         quotient     <= quotient_d;
         remainder    <= remainder_d;
         output_valid <= output_valid_d;
         busy         <= busy_d;
      end
   end

endmodule

// File: tb/tb_radix4_divider.sv
// Scoreboard bench for radix4_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every output_valid pulse.
module tb_radix4_divider;

   localparam int unsigned W = 32;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         input_valid = 1'b0;
   logic [W-1:0] quotient, remainder;
   logic         output_valid, busy;

   radix4_divider #(.WIDTH(W)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .dividend     (dividend),
      .divisor      (divisor),
      .input_valid  (input_valid),
      .quotient     (quotient),
      .remainder    (remainder),
      .output_valid (output_valid),
      .busy         (busy)
   );

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           e0;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_pulse = 0;
   int   n_push = 0;
   logic prev_ov = 1'b0;

   initial forever #5 clk_i = ~clk_i;
   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void gold(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == '0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input int e0);
      exp_t e;
      e.q  = q;
      e.r  = r;
      e.e0 = e0;
      sb.push_back(e);
      n_push++;
   endtask

   // Drive a one-cycle request; accept edge is the next posedge (cyc+1)
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit push);
      @(negedge clk_i);
      dividend    = a;
      divisor     = b;
      input_valid = 1'b1;
      if (push) push_exp(eq, er, cyc + 1);
      @(negedge clk_i);
      input_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (!output_valid && k < 40) begin
         @(negedge clk_i);
         k++;
      end
      chk("done_timeout", W'(output_valid), 1);
   endtask

   // Monitor
   initial forever begin
      exp_t e;
      @(negedge clk_i);
      if (output_valid) begin
         n_pulse++;
         chk("ov_single_cycle", W'(prev_ov), 0);
         chk("sb_nonempty", W'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("latency", W'(cyc - e.e0), 16);
         end
      end
      prev_ov = output_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [W-1:0] corner [8];
      logic [W-1:0] a, b, q, r;
      corner = '{32'h0, 32'h1, 32'h2, 32'h7, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h7FFF_FFFF, 32'h1234_5678};

      repeat (3) @(negedge clk_i);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_ov", W'(output_valid), 0);
      chk("rst_busy", W'(busy), 0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);

      // 100/7 with busy profile and hold check
      start(32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
      for (int i = 0; i < 16; i++) begin
         chk("busy_calc", W'(busy), 1);
         @(negedge clk_i);
      end
      chk("busy_done", W'(busy), 0);
      chk("ov_at_e16", W'(output_valid), 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         chk("hold_q", quotient, 32'd14);
         chk("hold_r", remainder, 32'd2);
      end

      start(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
      wait_done();
      start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
      wait_done();
      start(32'd3, 32'h8000_0000, 32'd0, 32'd3, 1'b1);
      wait_done();
      start(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      wait_done();
      start(32'd0, 32'd9, 32'd0, 32'd0, 1'b1);
      wait_done();

      // Request during CALC is ignored
      start(32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);
      repeat (4) @(negedge clk_i);
      dividend    = 32'd9;
      divisor     = 32'd2;
      input_valid = 1'b1;
      @(negedge clk_i);
      input_valid = 1'b0;
      wait_done();

      // Back-to-back restart from DONE
      @(negedge clk_i);
      dividend    = 32'd50;
      divisor     = 32'd6;
      input_valid = 1'b1;
      push_exp(32'd8, 32'd2, cyc + 1);
      @(negedge clk_i);
      dividend = 32'd77;
      divisor  = 32'd8;
      repeat (16) @(negedge clk_i);
      chk("b2b_first_ov", W'(output_valid), 1);
      push_exp(32'd9, 32'd5, cyc + 1);
      @(negedge clk_i);
      input_valid = 1'b0;
      chk("b2b_restart_busy", W'(busy), 1);
      wait_done();
      repeat (3) @(negedge clk_i);

      // Reset abort mid-CALC
      start(32'd1234, 32'd5, 32'd0, 32'd0, 1'b0);
      repeat (8) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      chk("abort_ov", W'(output_valid), 0);
      chk("abort_busy", W'(busy), 0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (30) @(negedge clk_i);
      start(32'd1234, 32'd5, 32'd246, 32'd4, 1'b1);
      wait_done();

      // Corner pairs and random sweep against golden model
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            gold(corner[i], corner[j], q, r);
            start(corner[i], corner[j], q, r, 1'b1);
            wait_done();
         end
      end
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         b = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom >> $urandom_range(0, 31));
         gold(a, b, q, r);
         start(a, b, q, r, 1'b1);
         wait_done();
      end

      repeat (5) @(negedge clk_i);
      chk("sb_drained", W'(sb.size()), 0);
      chk("pulse_count", W'(n_pulse), W'(n_push));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
